// File: rtl/vga_scan_gen_if.sv
// Scan-generator output bundle: timing strobes, syncs, pixel/tile coordinates and frame count.
interface vga_scan_gen_if;
  logic        pixel_ce;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [8:0]  tile_idx;
  logic [4:0]  tile_px;
  logic [4:0]  tile_py;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output pixel_ce, hs, vs, blank, DrawX, DrawY,
    output tile_idx, tile_px, tile_py, line_start, frame_start, frame_cnt
  );

  modport slave (
    input pixel_ce, hs, vs, blank, DrawX, DrawY,
    input tile_idx, tile_px, tile_py, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator with 32x32 tile addressing; every output is registered.
// Define VGA_FRAME_COUNT_EN to build the completed-frame counter (otherwise frame_cnt is tied to 0).
module vga_scan_gen #(
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int TILE_COLS = 20
) (
  input  logic          Clk,
  input  logic          Reset,
  vga_scan_gen_if.master vga
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG = V_VIS + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC - 1;

  logic       r_ce;
  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic [8:0] r_tile_idx;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_hc_nxt;
  logic [9:0] w_vc_nxt;
  logic       w_blank;
  logic       w_hs;
  logic       w_vs;
  logic [8:0] w_tile_idx;

  // The counters step at the end of each cycle in which pixel_ce is high.
  always_comb begin
    w_h_wrap = r_ce && (r_hc == 10'(H_TOT - 1));
    w_v_wrap = w_h_wrap && (r_vc == 10'(V_TOT - 1));
    w_hc_nxt = r_hc;
    w_vc_nxt = r_vc;
    if (r_ce) begin
      if (w_h_wrap) begin
        w_hc_nxt = 10'd0;
        if (w_v_wrap) begin
          w_vc_nxt = 10'd0;
        end else begin
          w_vc_nxt = r_vc + 10'd1;
        end
      end else begin
        w_hc_nxt = r_hc + 10'd1;
      end
    end else begin
      w_hc_nxt = r_hc;
    end
  end

  // Decode from the next counter values so registered outputs line up with DrawX/DrawY.
  always_comb begin
    w_blank = (w_hc_nxt >= 10'(H_VIS)) || (w_vc_nxt >= 10'(V_VIS));
    w_hs    = !((w_hc_nxt >= 10'(HS_BEG)) && (w_hc_nxt <= 10'(HS_END)));
    w_vs    = !((w_vc_nxt >= 10'(VS_BEG)) && (w_vc_nxt <= 10'(VS_END)));
    if (w_blank) begin
      w_tile_idx = 9'd0;
    end else begin
      w_tile_idx = ({4'd0, w_vc_nxt[9:5]} * 9'(TILE_COLS)) + {4'd0, w_hc_nxt[9:5]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ce          <= 1'b0;
      r_hc          <= 10'd0;
      r_vc          <= 10'd0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_tile_idx    <= 9'd0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_ce          <= ~r_ce;
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_blank       <= w_blank;
      r_tile_idx    <= w_tile_idx;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_cnt;

  // Counts completed frames, bumping on the same edge that raises frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_cnt <= 16'd0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  assign vga.frame_cnt = r_frame_cnt;
`else
  assign vga.frame_cnt = 16'd0;
`endif

  assign vga.pixel_ce    = r_ce;
  assign vga.hs          = r_hs;
  assign vga.vs          = r_vs;
  assign vga.blank       = r_blank;
  assign vga.DrawX       = r_hc;
  assign vga.DrawY       = r_vc;
  assign vga.tile_idx    = r_tile_idx;
  assign vga.tile_px     = r_hc[4:0];
  assign vga.tile_py     = r_vc[4:0];
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a reduced raster; every cycle is compared with a reference derived
// from the elapsed cycle count since reset, plus pulse counts over two frames and random resets.
module tb_vga_scan_gen;

  localparam int H_VIS = 96;
  localparam int H_FP = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP = 4;
  localparam int V_VIS = 64;
  localparam int V_FP = 3;
  localparam int V_SYNC = 2;
  localparam int V_BP = 3;
  localparam int TILE_COLS = 3;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = HT * VT * 2;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  vga_scan_gen_if vga ();

  vga_scan_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .TILE_COLS(TILE_COLS)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .vga(vga)
  );

  always #5 Clk = ~Clk;

  int n_asserts = 0;
  int n_fail = 0;
  int t = 0;
  int ls_cnt = 0;
  int fs_cnt = 0;
  int vs_low = 0;
  bit fc_en;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Reference: t cycles after the last reset edge, pixel n = t/2 has been reached.
  task automatic check_model();
    int n, ce, hc, vc, frames, tile, ls, fs, blank, hs, vs, fc;
    n      = t / 2;
    ce     = t % 2;
    hc     = n % HT;
    vc     = (n / HT) % VT;
    frames = n / (HT * VT);
    blank  = (hc >= H_VIS || vc >= V_VIS) ? 1 : 0;
    hs     = (hc >= H_VIS + H_FP && hc < H_VIS + H_FP + H_SYNC) ? 0 : 1;
    vs     = (vc >= V_VIS + V_FP && vc < V_VIS + V_FP + V_SYNC) ? 0 : 1;
    tile   = blank ? 0 : (vc / 32) * TILE_COLS + (hc / 32);
    ls     = (hc == 0 && n > 0 && ce == 0) ? 1 : 0;
    fs     = (ls == 1 && vc == 0) ? 1 : 0;
    fc     = fc_en ? (frames % 65536) : 0;
    chk("pixel_ce", 16'(vga.pixel_ce), 16'(ce));
    chk("DrawX", 16'(vga.DrawX), 16'(hc));
    chk("DrawY", 16'(vga.DrawY), 16'(vc));
    chk("blank", 16'(vga.blank), 16'(blank));
    chk("hs", 16'(vga.hs), 16'(hs));
    chk("vs", 16'(vga.vs), 16'(vs));
    chk("tile_idx", 16'(vga.tile_idx), 16'(tile));
    chk("tile_px", 16'(vga.tile_px), 16'(hc % 32));
    chk("tile_py", 16'(vga.tile_py), 16'(vc % 32));
    chk("line_start", 16'(vga.line_start), 16'(ls));
    chk("frame_start", 16'(vga.frame_start), 16'(fs));
    chk("frame_cnt", vga.frame_cnt, 16'(fc));
  endtask

  task automatic cyc(input logic r);
    Reset = r;
    @(posedge Clk);
    #1;
    if (r) t = 0;
    else t++;
    check_model();
    if (vga.line_start === 1'b1) ls_cnt++;
    if (vga.frame_start === 1'b1) fs_cnt++;
    if (vga.vs === 1'b0) vs_low++;
  endtask

  initial begin
`ifdef VGA_FRAME_COUNT_EN
    fc_en = 1'b1;
`else
    fc_en = 1'b0;
`endif
    // Reset held for three cycles, explicit reset-state checks
    for (int i = 0; i < 3; i++) cyc(1'b1);
    chk("rst_hs", 16'(vga.hs), 16'd1);
    chk("rst_vs", 16'(vga.vs), 16'd1);
    chk("rst_pixel_ce", 16'(vga.pixel_ce), 16'd0);
    chk("rst_frame_cnt", vga.frame_cnt, 16'd0);

    // Release and run exactly two frames
    ls_cnt = 0;
    fs_cnt = 0;
    vs_low = 0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) cyc(1'b0);
    chk("line_start_count", 16'(ls_cnt), 16'(2 * VT));
    chk("frame_start_count", 16'(fs_cnt), 16'd2);
    chk("vs_low_cycles", 16'(vs_low), 16'(2 * V_SYNC * HT * 2));
    chk("frame_cnt_2", vga.frame_cnt, fc_en ? 16'd2 : 16'd0);

    // Random-length runs each ended by a single-cycle mid-frame reset
    for (int k = 0; k < 5; k++) begin
      int len;
      len = int'($urandom_range(100, 4000));
      for (int i = 0; i < len; i++) cyc(1'b0);
      cyc(1'b1);
      chk("mid_rst_DrawX", 16'(vga.DrawX), 16'd0);
      chk("mid_rst_DrawY", 16'(vga.DrawY), 16'd0);
      chk("mid_rst_frame_start", 16'(vga.frame_start), 16'd0);
      chk("mid_rst_frame_cnt", vga.frame_cnt, 16'd0);
    end
    for (int i = 0; i < 600; i++) cyc(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
